multiple_instructions: RTL and testbench
========================================

// Module: multiple_instructions
// PURPOSE
//  Single-cycle RV32I integer-subset core: fetches one 32-bit instruction per clock
//  from an internal program memory, decodes/executes it in a child datapath and
//  writes the result to a 32x32 register file. Top-level of the CPU; no external bus.
//  Program is loaded hierarchically by the bench (no load port).
// PARAMETERS
//  PROG_DEPTH  64  program memory depth in 32-bit words (power of 2)
//  XLEN        32  data/register width (fixed at 32)
// PORTS
//  clk    in  1  rising-edge clock
//  reset  in  1  synchronous, active-high reset
// BEHAVIOUR
//  Fixed hierarchy (bench probes/loads these names):
//   - program_memory[0:PROG_DEPTH-1] : reg [31:0], word addressed, zero-initialised,
//     not touched by reset
//   - pc : word index into program_memory
//   - instruction : program_memory[pc] (combinational fetch)
//   - single_instr : datapath instance; single_instr.reg_mem.memory[0:31] register file
//  Reset (clk edge with reset=1): pc<=0, all 32 registers <=0. No execution that cycle.
//  Each posedge with reset=0: execute instruction at pc, write rd, pc<=pc+1.
//   - latency 1 clk: result visible in register file right after the executing edge
//   - first edge after reset deasserts executes program_memory[0]
//   - pc wraps PROG_DEPTH-1 -> 0
//  Register file: 2 combinational read ports (rs1, rs2), 1 synchronous write port;
//   x0 reads 0 always, writes to x0 discarded; read-during-write returns old value.
//  Decode (opcode[6:0], funct3[14:12], funct7[31:25]):
//   - 0010011 OP-IMM: imm = sign-extended instr[31:20]
//     000 ADDI, 010 SLTI, 011 SLTIU, 100 XORI, 110 ORI, 111 ANDI
//     001 SLLI, 101 SRLI/SRAI (funct7 0100000 = SRAI), shamt = instr[24:20]
//   - 0110011 OP: funct7 0000000 -> 000 ADD, 001 SLL, 010 SLT, 011 SLTU,
//     100 XOR, 101 SRL, 110 OR, 111 AND; funct7 0100000 -> 000 SUB, 101 SRA
//   - any other opcode/funct combination: NOP (no register write), pc still +1
//  Arithmetic: 32-bit two's complement, wrap on overflow, no flags/traps.
//   SLT/SLTI signed compare; SLTU/SLTIU unsigned (imm sign-extended first).
//   Shifts use low 5 bits of rs2 / shamt; SRA/SRAI replicate bit 31.
//  Boundaries: reset asserted mid-program aborts the current instruction (no write)
//   and restarts at pc 0 with cleared registers; all-zero word (unloaded memory)
//   is a NOP.
// CONFIGURATION
//  RV32I_SHIFT_EN defined: SLLI/SRLI/SRAI/SLL/SRL/SRA implemented as above.
//  Not defined: shifter omitted; all shift encodings decode as NOP (no write, pc+1).
// TESTING
//  1. prog: ADDI x5,x0,120; ADDI x5,x0,200; ADDI x5,x5,2000 -> x5=120, 200, 2200
//     after edges 1..3 post-reset.
//  2. then ANDI x5,x0,0xFFF; ORI x5,x0,0b1010 -> x5=0, then x5=10.
//  3. reset, prog: ADDI x29,x0,2; ADDI x31,x0,5; ADD x5,x31,x29; SUB x5,x31,x29
//     -> x29=2, x31=5, x5=7, x5=3.
//  4. ADDI x10,x0,2047; ADDI x11,x0,2047; SUB x6,x11,x10 -> x6=0 on third edge;
//     further zero words leave all registers unchanged.
//  5. ADDI x0,x0,5 -> x0 stays 0; SLTI x7,x0,-1 -> x7=0; SLTIU x7,x0,-1 -> x7=1.
//  6. reset high for one edge mid-program -> pc=0, x1..x31=0, no write that edge;
//     RV32I_SHIFT_EN: SRAI x8,x9,4 with x9=0x80000000 -> x8=0xF8000000.

Source files
------------

// File: rtl/multiple_instructions.sv
// multiple_instructions: single-cycle RV32I integer-subset core.
// One instruction per clock is fetched from program_memory[pc], executed in the
// datapath (single_instr) and written back to the 32x32 register file.
// Optional feature macro: RV32I_SHIFT_EN. When it is defined, the immediate and
// register shifts are implemented. When it is undefined, shift encodings act as NOPs.

// Register file: two combinational read ports and one synchronous write port. x0 is hard-wired to zero.
module reg_file #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      raddr1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata1_c,
  output logic [XLEN-1:0] rdata2_c,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata
);
  logic [XLEN-1:0] memory [0:31];

  // Reads see the pre-edge contents, so read-during-write returns the old value.
  always_comb begin
    rdata1_c = (raddr1 == 5'd0) ? '0 : memory[raddr1];
    rdata2_c = (raddr2 == 5'd0) ? '0 : memory[raddr2];
  end

  // Reset clears every register. Writes to x0 are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) memory[i] <= '0;
    end else if (we && (waddr != 5'd0)) begin
      memory[waddr] <= wdata;
    end
  end
endmodule

// Datapath: decodes and executes one OP / OP-IMM instruction per clock.
module datapath #(
  parameter int unsigned XLEN = 32
) (
  input logic        clk,
  input logic        reset,
  input logic [31:0] instruction
);
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  logic [6:0]      opcode;
  logic [4:0]      rd, rs1, rs2;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic            we_c;
  logic [XLEN-1:0] result_c;

  assign opcode = instruction[6:0];
  assign rd     = instruction[11:7];
  assign funct3 = instruction[14:12];
  assign rs1    = instruction[19:15];
  assign rs2    = instruction[24:20];
  assign funct7 = instruction[31:25];
  assign imm    = {{(XLEN-12){instruction[31]}}, instruction[31:20]};

  reg_file #(.XLEN(XLEN)) reg_mem (
    .clk      (clk),
    .reset    (reset),
    .raddr1   (rs1),
    .raddr2   (rs2),
    .rdata1_c (rs1_val),
    .rdata2_c (rs2_val),
    .we       (we_c),
    .waddr    (rd),
    .wdata    (result_c)
  );

`ifdef RV32I_SHIFT_EN
  logic [4:0] shamt;
  assign shamt = instruction[24:20];
`endif

  // Decode and ALU. Any encoding that is not listed clears we_c, so it behaves as a NOP.
  always_comb begin
    we_c     = 1'b0;
    result_c = '0;
    case (opcode)
      OPC_OPIMM: begin
        we_c = 1'b1;
        case (funct3)
          3'b000:  result_c = rs1_val + imm;
          3'b010:  result_c = XLEN'($signed(rs1_val) < $signed(imm));
          3'b011:  result_c = XLEN'(rs1_val < imm);
          3'b100:  result_c = rs1_val ^ imm;
          3'b110:  result_c = rs1_val | imm;
          3'b111:  result_c = rs1_val & imm;
`ifdef RV32I_SHIFT_EN
          3'b001: begin
            if (funct7 == F7_BASE) result_c = rs1_val << shamt;
            else                   we_c = 1'b0;
          end
          3'b101: begin
            if (funct7 == F7_BASE)     result_c = rs1_val >> shamt;
            else if (funct7 == F7_ALT) result_c = $signed(rs1_val) >>> shamt;
            else                       we_c = 1'b0;
          end
`endif
          default: we_c = 1'b0;
        endcase
      end
      OPC_OP: begin
        we_c = 1'b1;
        if (funct7 == F7_BASE) begin
          case (funct3)
            3'b000:  result_c = rs1_val + rs2_val;
            3'b010:  result_c = XLEN'($signed(rs1_val) < $signed(rs2_val));
            3'b011:  result_c = XLEN'(rs1_val < rs2_val);
            3'b100:  result_c = rs1_val ^ rs2_val;
            3'b110:  result_c = rs1_val | rs2_val;
            3'b111:  result_c = rs1_val & rs2_val;
`ifdef RV32I_SHIFT_EN
            3'b001:  result_c = rs1_val << rs2_val[4:0];
            3'b101:  result_c = rs1_val >> rs2_val[4:0];
`endif
            default: we_c = 1'b0;
          endcase
        end else if (funct7 == F7_ALT) begin
          case (funct3)
            3'b000:  result_c = rs1_val - rs2_val;
`ifdef RV32I_SHIFT_EN
            3'b101:  result_c = $signed(rs1_val) >>> rs2_val[4:0];
`endif
            default: we_c = 1'b0;
          endcase
        end else begin
          we_c = 1'b0;
        end
      end
      default: we_c = 1'b0;
    endcase
  end
endmodule

// Top level: program memory, program counter and datapath.
module multiple_instructions #(
  parameter int unsigned PROG_DEPTH = 64,
  parameter int unsigned XLEN       = 32
) (
  input logic clk,
  input logic reset
);
  localparam int unsigned PC_W = $clog2(PROG_DEPTH);

  // Program memory has no load port. It is loaded from outside and is not affected by reset.
  logic [31:0]     program_memory [0:PROG_DEPTH-1];
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_d;
  logic [31:0]     instruction;

  assign instruction = program_memory[pc];

  // The next pc is always pc+1. PROG_DEPTH is a power of two, so the value wraps to 0 naturally.
  always_comb begin
    pc_d = pc + PC_W'(1);
  end

  // Program counter register. Reset restarts execution at word 0.
  always_ff @(posedge clk) begin
    if (reset) pc <= '0;
    else       pc <= pc_d;
  end

  datapath #(.XLEN(XLEN)) single_instr (
    .clk         (clk),
    .reset       (reset),
    .instruction (instruction)
  );
endmodule

// File: tb/tb_multiple_instructions.sv
// Directed table-driven bench for the multiple_instructions RV32I subset core.
module tb_multiple_instructions;
`ifdef RV32I_SHIFT_EN
  localparam bit SH = 1'b1;
`else
  localparam bit SH = 1'b0;
`endif

  logic clk;
  logic reset;

  multiple_instructions dut (
    .clk   (clk),
    .reset (reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          new_prog;
    string       name;
    logic [31:0] instr;
    logic [4:0]  rchk;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [31:0] enc_i(input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_sh(input logic [6:0] f7, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [4:0] shamt);
    return {f7, shamt, rs1, f3, rd, 7'b0010011};
  endfunction

  task automatic add(input bit np, input string nm, input logic [31:0] ins,
                     input logic [4:0] r, input logic [31:0] e);
    vec_t v;
    v.new_prog = np; v.name = nm; v.instr = ins; v.rchk = r; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rf(input logic [4:0] r);
    return dut.single_instr.reg_mem.memory[r];
  endfunction

  task automatic clear_prog();
    for (int k = 0; k < 64; k++) dut.program_memory[k] = 32'h0;
  endtask

  logic [31:0] or_all;

  initial begin
    // Segment A: OP-IMM basics
    add(1, "addi120",    enc_i(3'b000, 5, 0, 12'd120),   5, 32'd120);
    add(0, "addi200",    enc_i(3'b000, 5, 0, 12'd200),   5, 32'd200);
    add(0, "addi_acc",   enc_i(3'b000, 5, 5, 12'd2000),  5, 32'd2200);
    add(0, "andi_fff",   enc_i(3'b111, 5, 0, 12'hFFF),   5, 32'd0);
    add(0, "ori_10",     enc_i(3'b110, 5, 0, 12'b1010),  5, 32'd10);
    add(0, "addi_x7",    enc_i(3'b000, 7, 0, 12'd9),     7, 32'd9);
    add(0, "slti_m1",    enc_i(3'b010, 7, 0, 12'hFFF),   7, 32'd0);
    add(0, "sltiu_m1",   enc_i(3'b011, 7, 0, 12'hFFF),   7, 32'd1);
    add(0, "addi_x0",    enc_i(3'b000, 0, 0, 12'd5),     0, 32'd0);
    add(0, "xori_neg",   enc_i(3'b100, 8, 5, 12'hFFA),   8, 32'hFFFF_FFF0);
    add(0, "addi_min",   enc_i(3'b000, 9, 0, 12'h800),   9, 32'hFFFF_F800);
    add(0, "slti_sgn",   enc_i(3'b010, 10, 9, 12'h801), 10, 32'd1);
    add(0, "sltiu_sgn",  enc_i(3'b011, 11, 9, 12'hFFF), 11, 32'd1);
    add(0, "ecall_nop",  32'h0000_0073,                  5, 32'd10);
    add(0, "addi_m1",    enc_i(3'b000, 12, 0, 12'hFFF), 12, 32'hFFFF_FFFF);
    add(0, "addi_wrap",  enc_i(3'b000, 12, 12, 12'd1),  12, 32'd0);
    // Segment B: OP register-register
    add(1, "addi_x29",   enc_i(3'b000, 29, 0, 12'd2),   29, 32'd2);
    add(0, "addi_x31",   enc_i(3'b000, 31, 0, 12'd5),   31, 32'd5);
    add(0, "add",        enc_r(7'b0000000, 3'b000, 5, 31, 29),   5, 32'd7);
    add(0, "sub",        enc_r(7'b0100000, 3'b000, 5, 31, 29),   5, 32'd3);
    add(0, "bad_f7_nop", enc_r(7'b0100000, 3'b001, 5, 31, 29),   5, 32'd3);
    add(0, "sub_neg",    enc_r(7'b0100000, 3'b000, 12, 29, 31), 12, 32'hFFFF_FFFD);
    add(0, "slt",        enc_r(7'b0000000, 3'b010, 13, 12, 29), 13, 32'd1);
    add(0, "sltu",       enc_r(7'b0000000, 3'b011, 14, 29, 12), 14, 32'd1);
    add(0, "xor",        enc_r(7'b0000000, 3'b100, 15, 31, 29), 15, 32'd7);
    add(0, "or",         enc_r(7'b0000000, 3'b110, 16, 31, 12), 16, 32'hFFFF_FFFD);
    add(0, "and",        enc_r(7'b0000000, 3'b111, 17, 12, 31), 17, 32'd5);
    // Segment C: SUB to zero, then unloaded (all-zero) words as NOPs
    add(1, "addi_2047a", enc_i(3'b000, 10, 0, 12'd2047), 10, 32'd2047);
    add(0, "addi_2047b", enc_i(3'b000, 11, 0, 12'd2047), 11, 32'd2047);
    add(0, "sub_zero",   enc_r(7'b0100000, 3'b000, 6, 11, 10), 6, 32'd0);
    add(0, "zero_x10",   32'h0, 10, 32'd2047);
    add(0, "zero_x6",    32'h0,  6, 32'd0);
    add(0, "zero_x11",   32'h0, 11, 32'd2047);
    // Segment D: shifts (NOPs when the shifter is not built)
    add(1, "addi_x9",    enc_i(3'b000, 9, 0, 12'd1),  9, 32'd1);
    add(0, "addi_x8",    enc_i(3'b000, 8, 0, 12'd7),  8, 32'd7);
    add(0, "slli31",     enc_sh(7'b0000000, 3'b001, 9, 9, 5'd31),  9, SH ? 32'h8000_0000 : 32'd1);
    add(0, "srai4",      enc_sh(7'b0100000, 3'b101, 8, 9, 5'd4),   8, SH ? 32'hF800_0000 : 32'd7);
    add(0, "srli4",      enc_sh(7'b0000000, 3'b101, 19, 9, 5'd4), 19, SH ? 32'h0800_0000 : 32'd0);
    add(0, "addi_33",    enc_i(3'b000, 20, 0, 12'd33), 20, 32'd33);
    add(0, "sra",        enc_r(7'b0100000, 3'b101, 21, 9, 20),  21, SH ? 32'hC000_0000 : 32'd0);
    add(0, "sll",        enc_r(7'b0000000, 3'b001, 22, 20, 20), 22, SH ? 32'd66 : 32'd0);
    add(0, "srl",        enc_r(7'b0000000, 3'b101, 23, 9, 20),  23, SH ? 32'h4000_0000 : 32'd0);
    add(0, "slli_badf7", enc_sh(7'b0100000, 3'b001, 8, 9, 5'd1), 8, SH ? 32'hF800_0000 : 32'd7);

    // Reset state
    reset = 1'b1;
    clear_prog();
    repeat (2) @(posedge clk);
    #1;
    or_all = 32'h0;
    for (int r = 0; r < 32; r++) or_all = or_all | rf(5'(r));
    check("reset_regs", or_all, 32'h0);
    check("reset_pc", 32'(dut.pc), 32'd0);

    // Table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].new_prog) begin
        reset = 1'b1;
        clear_prog();
        for (int j = i; j < vecs.size(); j++) begin
          if (j > i && vecs[j].new_prog) break;
          dut.program_memory[j - i] = vecs[j].instr;
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
      end
      @(posedge clk);
      #1;
      check(vecs[i].name, rf(vecs[i].rchk), vecs[i].exp);
    end

    // Mid-program reset: the instruction at pc must not write, and execution restarts at word 0
    reset = 1'b1;
    clear_prog();
    dut.program_memory[0] = enc_i(3'b000, 3, 0, 12'd77);
    dut.program_memory[1] = enc_i(3'b000, 4, 0, 12'd5);
    dut.program_memory[2] = enc_i(3'b000, 3, 0, 12'd99);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("mr_x3_first", rf(5'd3), 32'd77);
    @(posedge clk); #1;
    check("mr_x4", rf(5'd4), 32'd5);
    reset = 1'b1;
    @(posedge clk); #1;
    check("mr_pc", 32'(dut.pc), 32'd0);
    check("mr_x3_clr", rf(5'd3), 32'd0);
    check("mr_x4_clr", rf(5'd4), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("mr_restart_x3", rf(5'd3), 32'd77);
    check("mr_restart_pc", 32'(dut.pc), 32'd1);

    // pc wrap: every word increments x1
    reset = 1'b1;
    for (int k = 0; k < 64; k++) dut.program_memory[k] = enc_i(3'b000, 1, 1, 12'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (64) @(posedge clk);
    #1;
    check("wrap_x1_64", rf(5'd1), 32'd64);
    check("wrap_pc0", 32'(dut.pc), 32'd0);
    @(posedge clk); #1;
    check("wrap_x1_65", rf(5'd1), 32'd65);
    check("wrap_pc1", 32'(dut.pc), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
